// File: rtl/hps_uart0_fabric_tx.sv
// Fabric-side 8N1/8N2 UART transmitter driving the HPS UART0 RX pin.
// A byte FIFO behind valid/ready feeds a serializer clocked by a baud divider.
module hps_uart0_fabric_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW       = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            txd_q;
  logic            busy_q;
  logic            ready_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [LvlW-1:0] count_q;
  logic [LvlW-1:0] count_d;

  logic            baud_tc;
  logic            stop_last;
  logic            push;
  logic            pop;

  always_comb begin
    baud_tc   = (baud_cnt_q == CntW'(ClksPerBit - 1));
    stop_last = (bit_cnt_q == 3'(STOP_BITS - 1));
    push      = tx_valid & ready_q;
    // Pop from IDLE, or at the very last stop cycle for back-to-back frames.
    pop       = (count_q != '0) &&
                ((state_q == StIdle) || ((state_q == StStop) && baud_tc && stop_last));
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != LvlW'(FIFO_DEPTH));
    end
  end

  // The line flop follows the state one cycle later, so every bit still lasts
  // exactly ClksPerBit cycles and the line is never combinational.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      busy_q     <= 1'b1;
      baud_cnt_q <= baud_tc ? '0 : baud_cnt_q + CntW'(1);
      case (state_q)
        StIdle: begin
          txd_q      <= 1'b1;
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= StStart;
          end else begin
            busy_q <= (count_d != '0);
          end
        end
        StStart: begin
          txd_q <= 1'b0;
          if (baud_tc) begin
            state_q <= StData;
          end
        end
        StData: begin
          txd_q <= shift_q[0];
          if (baud_tc) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              state_q   <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        StStop: begin
          txd_q <= 1'b1;
          if (baud_tc) begin
            if (stop_last) begin
              bit_cnt_q <= '0;
              if (pop) begin
                shift_q <= mem_q[rd_ptr_q];
                state_q <= StStart;
              end else begin
                state_q <= StIdle;
                busy_q  <= (count_d != '0);
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx_ready   = ready_q;
  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_hps_uart0_fabric_tx.sv
// Bench for hps_uart0_fabric_tx: queue/timeline model checked every cycle on a
// fast-baud instance, plus literal checks on a default-rate 2-stop-bit instance.
module tb_hps_uart0_fabric_tx;

  localparam int C = 11;       // 1_000_000 / 90_000 truncated
  localparam int F = 10 * C;   // 8N1 frame length
  localparam int D = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic [3:0] fifo_level;

  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       uart_txd2;
  logic       tx_busy2;
  logic [3:0] fifo_level2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_prints = 0;
  int peak = 0;

  logic [7:0] mq[$];
  logic [7:0] rxq[$];
  bit         m_active = 1'b0;
  int         m_j = 0;
  logic [7:0] m_byte = 8'h00;

  hps_uart0_fabric_tx #(
    .CLK_HZ    (1000000),
    .BAUD      (90000),
    .FIFO_DEPTH(8),
    .STOP_BITS (1)
  ) u_dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .uart_txd     (uart_txd),
    .tx_busy      (tx_busy),
    .fifo_level   (fifo_level)
  );

  hps_uart0_fabric_tx #(
    .STOP_BITS(2)
  ) u_dut2 (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .tx_data      (tx_data2),
    .tx_valid     (tx_valid2),
    .tx_ready     (tx_ready2),
    .uart_txd     (uart_txd2),
    .tx_busy      (tx_busy2),
    .fifo_level   (fifo_level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] b);
    logic r;
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    do begin
      r = tx_ready;
      adv(1);
      n++;
    end while (!r && n < 2000);
    tx_valid = 1'b0;
    check("push_accepted", 32'(r), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_busy && n < 5000) begin
      adv(1);
      n++;
    end
    adv(2);
    check(name, 32'(tx_busy), 0);
  endtask

  // Line level implied by the frame timeline: j edges after the pop edge.
  function automatic logic exp_line();
    int idx;
    if (!m_active || m_j == 0) return 1'b1;
    idx = (m_j - 1) / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  initial begin : model
    int pre;
    bit do_pop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_active = 1'b0;
        m_j = 0;
      end else begin
        pre = mq.size();
        if (m_active) m_j++;
        do_pop = (pre > 0) && (!m_active || m_j == F);
        if (m_active && m_j == F && !do_pop) m_active = 1'b0;
        if (tx_valid && pre < D) mq.push_back(tx_data);
        if (do_pop) begin
          m_byte   = mq.pop_front();
          m_active = 1'b1;
          m_j      = 0;
        end
      end
    end
  end

  initial begin : compare
    logic el, eb, er;
    logic [3:0] elv;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        el  = exp_line();
        eb  = m_active || (mq.size() > 0);
        er  = (mq.size() < D);
        elv = 4'(mq.size());
        n_tests++;
        if (uart_txd !== el || tx_busy !== eb || tx_ready !== er || fifo_level !== elv) begin
          n_fail++;
          if (n_prints < 20) begin
            n_prints++;
            $display("FAIL cycle_model @%0t: txd/busy/ready/level got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                     $time, uart_txd, tx_busy, tx_ready, fifo_level, el, eb, er, elv);
          end
        end
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
    end
  end

  initial begin : rx_monitor
    logic prev;
    bit rx_on;
    int k;
    logic [9:0] sh;
    prev = 1'b1;
    rx_on = 1'b0;
    k = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        rx_on = 1'b0;
        prev = 1'b1;
      end else begin
        if (!rx_on) begin
          if (prev && !uart_txd) begin
            rx_on = 1'b1;
            k = 0;
          end
        end else begin
          k++;
        end
        if (rx_on && (k % C) == C / 2) begin
          sh[k/C] = uart_txd;
          if (k / C == 9) begin
            rx_on = 1'b0;
            check("rx_stop_bit", 32'(uart_txd), 1);
            rxq.push_back(sh[8:1]);
          end
        end
        prev = uart_txd;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] t1_bits;
    logic [7:0] t3 [12];
    int acc_at [12];
    int i, t, hi;
    logic r;

    t1_bits = 10'b1010101010;
    t3 = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h7E, 8'hE7, 8'h12, 8'h34, 8'hF0, 8'h0F};
    for (int k = 0; k < 12; k++) acc_at[k] = -1;

    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tx_valid2 = 1'b0;
    tx_data2 = 8'h00;
    adv(3);
    check("rst_txd", 32'(uart_txd), 1);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_txd2", 32'(uart_txd2), 1);
    rst_n = 1'b1;
    adv(3);

    // 1: single 0x55
    push1(8'h55);
    check("t1_level_n", 32'(fifo_level), 1);
    check("t1_busy_n", 32'(tx_busy), 1);
    adv(1);
    check("t1_level_pop", 32'(fifo_level), 0);
    check("t1_line_n1", 32'(uart_txd), 1);
    adv(1);
    check("t1_start_n2", 32'(uart_txd), 0);
    for (int b = 1; b <= 9; b++) begin
      adv(C);
      check("t1_bit", 32'(uart_txd), 32'(t1_bits[b]));
    end
    adv(9);
    check("t1_busy_last", 32'(tx_busy), 1);
    adv(1);
    check("t1_busy_end", 32'(tx_busy), 0);
    check("t1_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("t1_rx_byte", 32'(rxq[0]), 32'h55);
    rxq.delete();
    adv(5);

    // 2: three back-to-back frames
    peak = 0;
    push1(8'hA3);
    push1(8'h00);
    push1(8'hFF);
    check("t2_level", 32'(fifo_level), 2);
    adv(109);
    check("t2_stop1", 32'(uart_txd), 1);
    adv(1);
    check("t2_start2", 32'(uart_txd), 0);
    adv(109);
    check("t2_stop2", 32'(uart_txd), 1);
    adv(1);
    check("t2_start3", 32'(uart_txd), 0);
    adv(108);
    check("t2_busy_last", 32'(tx_busy), 1);
    adv(1);
    check("t2_busy_end", 32'(tx_busy), 0);
    check("t2_peak", peak, 2);
    check("t2_rx_count", rxq.size(), 3);
    if (rxq.size() == 3) begin
      check("t2_rx0", 32'(rxq[0]), 32'hA3);
      check("t2_rx1", 32'(rxq[1]), 32'h00);
      check("t2_rx2", 32'(rxq[2]), 32'hFF);
    end
    rxq.delete();
    adv(5);

    // 3+4: stream 12 bytes with tx_valid held high
    peak = 0;
    i = 0;
    t = 0;
    tx_valid = 1'b1;
    while (i < 12 && t < 2000) begin
      tx_data = t3[i];
      r = tx_ready;
      adv(1);
      if (r) begin
        acc_at[i] = t;
        i++;
      end
      t++;
    end
    tx_valid = 1'b0;
    check("t3_accepted", i, 12);
    check("t3_acc8", acc_at[8], 8);
    check("t4_acc9_after_full", acc_at[9], 112);
    check("t4_acc10", acc_at[10], 222);
    check("t4_acc11", acc_at[11], 332);
    wait_idle("t3_idle");
    check("t3_peak", peak, 8);
    check("t3_rx_count", rxq.size(), 12);
    for (int k = 0; k < 12 && k < rxq.size(); k++) check("t3_rx_byte", 32'(rxq[k]), 32'(t3[k]));
    rxq.delete();
    adv(5);

    // 5: reset mid-data of the second of three frames
    push1(8'h11);
    push1(8'h22);
    push1(8'h33);
    adv(149);
    check("t5_line_before", 32'(uart_txd), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_line_async", 32'(uart_txd), 1);
    check("t5_level_async", 32'(fifo_level), 0);
    check("t5_busy_async", 32'(tx_busy), 0);
    adv(2);
    rst_n = 1'b1;
    adv(300);
    check("t5_no_frames_busy", 32'(tx_busy), 0);
    check("t5_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("t5_rx0", 32'(rxq[0]), 32'h11);
    push1(8'h5A);
    wait_idle("t5_idle");
    check("t5_rx_count2", rxq.size(), 2);
    if (rxq.size() == 2) check("t5_rx1", 32'(rxq[1]), 32'h5A);
    rxq.delete();

    // 6: default rate, two stop bits, 0x0F
    tx_data2 = 8'h0F;
    tx_valid2 = 1'b1;
    r = tx_ready2;
    adv(1);
    tx_valid2 = 1'b0;
    check("t6_ready", 32'(r), 1);
    check("t6_busy_n", 32'(tx_busy2), 1);
    adv(1);
    check("t6_line_n1", 32'(uart_txd2), 1);
    adv(1);
    check("t6_start", 32'(uart_txd2), 0);
    adv(434);
    check("t6_bit0", 32'(uart_txd2), 1);
    adv(3471);
    check("t6_bit7", 32'(uart_txd2), 0);
    hi = 0;
    for (int k = 1; k <= 868; k++) begin
      adv(1);
      if (uart_txd2 === 1'b1) hi++;
      if (k == 867) check("t6_busy_last", 32'(tx_busy2), 1);
    end
    check("t6_stop_high", hi, 868);
    check("t6_busy_end", 32'(tx_busy2), 0);
    check("t6_level", 32'(fifo_level2), 0);

    adv(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
